// File: rtl/bus_fifo_arb.sv
// bus_fifo_arb: round-robin, burst-bounded write arbiter for the bus FIFO plus
// a registered valid/ready drain stage on its read side.
module bus_fifo_arb #(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*DATA_W-1:0]    req_data,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       fifo_w_en,
   output logic [DATA_W-1:0]          fifo_data_w,
   output logic                       fifo_r_en,
   input  logic [DATA_W-1:0]          fifo_data_r,
   input  logic                       fifo_full,
   input  logic                       fifo_empty,
   input  logic                       fifo_overflow,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   input  logic                       out_ready,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       err_ovf
);
   localparam int GW = $clog2(N_REQ);
   typedef enum logic {ARB, GRANT} state_t;
   state_t          r_state, w_next;
   logic [GW-1:0]   r_rr_ptr, r_grant_id, w_pick, w_rr_next;
   logic [3:0]      r_burst_cnt;
   logic            w_any, w_hold, w_xfer, w_last;
   logic            r_out_valid, r_err_ovf;
   logic [DATA_W-1:0] r_out_data;

   // Scan downward so the candidate closest to rr_ptr is the one that sticks.
   always_comb begin
      w_pick = r_rr_ptr;
      w_any  = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_valid[GW'((int'(r_rr_ptr) + i) % N_REQ)]) begin
            w_pick = GW'((int'(r_rr_ptr) + i) % N_REQ);
            w_any  = 1'b1;
         end
      end
   end

   assign w_hold    = req_valid[r_grant_id];
   assign w_xfer    = rst_n & (r_state == GRANT) & w_hold & ~fifo_full;
   assign w_last    = w_xfer & (r_burst_cnt == 4'(MAX_BURST - 1));
   assign w_rr_next = (r_grant_id == GW'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ARB;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (r_state == ARB) w_next = w_any ? GRANT : ARB;
      else                w_next = (~w_hold | w_last) ? ARB : GRANT;
   end

   always_comb begin
      req_ready   = (rst_n && r_state == GRANT && !fifo_full) ? N_REQ'(1) << r_grant_id : '0;
      fifo_w_en   = w_xfer;
      fifo_data_w = req_data[r_grant_id*DATA_W +: DATA_W];
      fifo_r_en   = rst_n & ~fifo_empty & (~r_out_valid | out_ready);
      grant_id    = r_grant_id;
      out_valid   = r_out_valid;
      out_data    = r_out_data;
      err_ovf     = r_err_ovf;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr    <= '0;
         r_grant_id  <= '0;
         r_burst_cnt <= '0;
      end else if (r_state == ARB) begin
         if (w_any) begin
            r_grant_id  <= w_pick;
            r_burst_cnt <= '0;
         end
      end else begin
         if (w_xfer) r_burst_cnt <= r_burst_cnt + 4'd1;
         if (w_next == ARB) r_rr_ptr <= w_rr_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_err_ovf   <= 1'b0;
      end else begin
         if (fifo_r_en) begin
            r_out_data  <= fifo_data_r;
            r_out_valid <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (fifo_overflow) r_err_ovf <= 1'b1;
      end
   end
endmodule

// File: tb/tb_bus_fifo_arb.sv
// tb_bus_fifo_arb: directed bench for bus_fifo_arb driving a behavioural 16-deep FIFO.
module tb_bus_fifo_arb;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, fifo_rst_n, ovf_force;
   logic [3:0]   req_valid, req_ready;
   logic [127:0] req_data;
   logic         fifo_w_en, fifo_r_en, fifo_full, fifo_empty, fifo_overflow;
   logic [31:0]  fifo_data_w, fifo_data_r, out_data;
   logic         out_valid, out_ready, err_ovf;
   logic [1:0]   grant_id;
   int checks = 0, errors = 0, sent, got, viol;

   bit          t1_v  [7] = '{1, 1, 1, 1, 0, 0, 0};
   logic [31:0] t1_in [7] = '{32'hA0, 32'hA0, 32'hA1, 32'hA2, 0, 0, 0};
   bit          t1_w  [7] = '{0, 1, 1, 1, 0, 0, 0};
   bit          t1_ov [7] = '{0, 0, 0, 1, 1, 1, 0};
   logic [31:0] t1_od [7] = '{0, 0, 0, 32'hA0, 32'hA1, 32'hA2, 0};

   bus_fifo_arb dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .fifo_w_en(fifo_w_en), .fifo_data_w(fifo_data_w),
      .fifo_r_en(fifo_r_en), .fifo_data_r(fifo_data_r), .fifo_full(fifo_full),
      .fifo_empty(fifo_empty), .fifo_overflow(fifo_overflow), .out_valid(out_valid),
      .out_data(out_data), .out_ready(out_ready), .grant_id(grant_id), .err_ovf(err_ovf)
   );

   // Behavioural FIFO with its own reset so words survive an arbiter reset.
   logic [31:0] mem [16];
   int wp, rp, cnt;
   assign fifo_full     = (cnt == 16);
   assign fifo_empty    = (cnt == 0);
   assign fifo_data_r   = mem[rp];
   assign fifo_overflow = ovf_force | (fifo_w_en & fifo_full);
   always @(posedge clk) if (fifo_w_en && cnt < 16) mem[wp] <= fifo_data_w;
   always @(posedge clk or negedge fifo_rst_n) begin
      if (!fifo_rst_n) begin
         wp <= 0; rp <= 0; cnt <= 0;
      end else begin
         if (fifo_w_en && cnt < 16) wp <= (wp + 1) % 16;
         if (fifo_r_en && cnt > 0) rp <= (rp + 1) % 16;
         cnt <= cnt + ((fifo_w_en && cnt < 16) ? 1 : 0) - ((fifo_r_en && cnt > 0) ? 1 : 0);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic full_reset;
      rst_n = 0; fifo_rst_n = 0; req_valid = '0; out_ready = 0; ovf_force = 0;
      step; step;
      rst_n = 1; fifo_rst_n = 1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 0; fifo_rst_n = 0; req_valid = '1; req_data = '0; out_ready = 1; ovf_force = 0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_err_ovf", err_ovf, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_w_en", fifo_w_en, 0);
      chk("rst_r_en", fifo_r_en, 0);

      // Single requester, three words
      full_reset;
      for (int k = 0; k < 7; k++) begin
         step;
         out_ready = 1;
         req_valid = {3'b000, t1_v[k]};
         req_data[31:0] = t1_in[k];
         @(negedge clk);
         chk("t1_w_en", fifo_w_en, t1_w[k]);
         if (t1_w[k]) chk("t1_wdata", fifo_data_w, t1_in[k]);
         chk("t1_out_valid", out_valid, t1_ov[k]);
         if (t1_ov[k]) chk("t1_out_data", out_data, t1_od[k]);
      end

      // Round robin, all requesters continuously valid
      full_reset;
      for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'h100 * (i + 1);
      for (int k = 0; k < 25; k++) begin
         int g;
         bit we;
         step;
         out_ready = 1;
         req_valid = '1;
         @(negedge clk);
         g  = (k / 5) % 4;
         we = (k % 5) != 0;
         chk("t2_w_en", fifo_w_en, we);
         if (we) begin
            chk("t2_grant", grant_id, g);
            chk("t2_ready", req_ready, 32'(1) << g);
            chk("t2_wdata", fifo_data_w, 32'h100 * (g + 1));
         end else begin
            chk("t2_idle_ready", req_ready, 0);
         end
      end

      // Backpressure: 17 words with consumer stalled
      full_reset;
      sent = 0; viol = 0;
      for (int c = 0; c < 80 && sent < 17; c++) begin
         step;
         req_valid = 4'b0001;
         req_data[31:0] = 32'hB00 + sent;
         @(negedge clk);
         if (fifo_w_en && fifo_full) viol++;
         if (req_valid[0] && req_ready[0]) sent++;
      end
      chk("t3_sent", sent, 17);
      for (int c = 0; c < 3; c++) begin
         step;
         req_data[31:0] = 32'hB00 + 17;
         @(negedge clk);
         chk("t3_full", fifo_full, 1);
         chk("t3_ready_low", req_ready, 0);
         chk("t3_w_en_low", fifo_w_en, 0);
      end
      chk("t3_no_wen_full", viol, 0);
      chk("t3_err_ovf", err_ovf, 0);
      got = 0;
      for (int c = 0; c < 60 && got < 17; c++) begin
         step;
         req_valid = '0;
         out_ready = 1;
         @(negedge clk);
         if (out_valid) begin
            chk("t3_order", out_data, 32'hB00 + got);
            got++;
         end
      end
      chk("t3_got", got, 17);
      step;
      @(negedge clk);
      chk("t3_drained_valid", out_valid, 0);
      chk("t3_drained_empty", fifo_empty, 1);

      // Early release: req 2 drops after one word
      full_reset;
      req_data[2*32 +: 32] = 32'h200;
      req_data[3*32 +: 32] = 32'h300;
      step; out_ready = 1; req_valid = 4'b1100;
      @(negedge clk);
      chk("t4_arb_w_en", fifo_w_en, 0);
      step;
      @(negedge clk);
      chk("t4_grant2", grant_id, 2);
      chk("t4_w_en2", fifo_w_en, 1);
      chk("t4_wdata2", fifo_data_w, 32'h200);
      step; req_valid = 4'b1000;
      @(negedge clk);
      chk("t4_drop_w_en", fifo_w_en, 0);
      step;
      @(negedge clk);
      chk("t4_idle_w_en", fifo_w_en, 0);
      chk("t4_rr_ptr", dut.r_rr_ptr, 3);
      step;
      @(negedge clk);
      chk("t4_grant3", grant_id, 3);
      chk("t4_ready3", req_ready, 4'b1000);
      chk("t4_wdata3", fifo_data_w, 32'h300);

      // Overflow flag is sticky
      step; req_valid = '0; out_ready = 0; ovf_force = 1;
      @(negedge clk);
      chk("t6_ovf_before", err_ovf, 0);
      step; ovf_force = 0;
      @(negedge clk);
      chk("t6_ovf_set", err_ovf, 1);
      step; step;
      @(negedge clk);
      chk("t6_ovf_sticky", err_ovf, 1);

      // Reset during requester 1's second word
      req_data[1*32 +: 32] = 32'h111;
      step; req_valid = 4'b0010;
      @(negedge clk);
      chk("t5_arb_w_en", fifo_w_en, 0);
      step;
      @(negedge clk);
      chk("t5_grant1", grant_id, 1);
      chk("t5_first_w_en", fifo_w_en, 1);
      chk("t5_out_valid_held", out_valid, 1);
      step; req_data[1*32 +: 32] = 32'h112; out_ready = 1;
      #1;
      chk("t5_pre_w_en", fifo_w_en, 1);
      chk("t5_pre_r_en", fifo_r_en, 1);
      rst_n = 0;
      #1;
      chk("t5_rst_out_valid", out_valid, 0);
      chk("t5_rst_err_ovf", err_ovf, 0);
      chk("t5_rst_w_en", fifo_w_en, 0);
      chk("t5_rst_r_en", fifo_r_en, 0);
      chk("t5_rst_ready", req_ready, 0);
      step; req_valid = 4'b0011; rst_n = 1;
      @(negedge clk);
      chk("t5_post_arb_w_en", fifo_w_en, 0);
      chk("t5_post_arb_ready", req_ready, 0);
      step;
      @(negedge clk);
      chk("t5_post_grant", grant_id, 0);
      chk("t5_post_ready", req_ready, 4'b0001);
      chk("t5_post_w_en", fifo_w_en, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
